qbu_rx_smd_dispatch: RTL and testbench
======================================

QBU_RX_SMD_DISPATCH -- requirements
Module: qbu_rx_smd_dispatch

Interface
REQ-001 SHALL have parameter DWIDTH, default 8, meaning the stream data width; only 8 is supported.
REQ-002 SHALL have port i_clk, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-003 SHALL have port i_rst_n, input, 1 bit: asynchronous active-low reset.
REQ-004 SHALL have input stream ports, carrying raw mPackets from preamble through FCS/mCRC:
- i_rx_axis_data, input, DWIDTH
- i_rx_axis_valid, input, 1
- i_rx_axis_last, input, 1
- o_rx_axis_ready, output, 1
REQ-005 SHALL have express output ports:
- o_emac_axis_data, output, DWIDTH
- o_emac_axis_user, output, 16
- o_emac_axis_keep, output, DWIDTH/8
- o_emac_axis_last, output, 1
- o_emac_axis_valid, output, 1
- i_emac_axis_ready, input, 1
REQ-006 SHALL have preemptable output ports, identical to REQ-005 with prefix pmac.
REQ-007 SHALL have status ports:
- o_smd_err, output, 1: one-cycle error pulse.
- o_err_cnt, output, 16: saturating error count.

Function
REQ-008 SHALL implement states IDLE, PRE, FRAG, EXP, PMT, DROP; a beat is accepted when valid and ready are both high.
REQ-009 SHALL drive o_rx_ready as follows:
- 1 in IDLE, PRE, FRAG and DROP.
- In EXP: ~o_emac_axis_valid | i_emac_axis_ready.
- In PMT: ~o_pmac_axis_valid | i_pmac_axis_ready.
REQ-010 IDLE SHALL behave as follows:
- Accepted 0x55: go to PRE, preamble count = 1.
- Any other byte: error; go to DROP, or stay in IDLE if last.
REQ-011 PRE SHALL handle an accepted 0x55 byte as follows:
- Count < 7: increment the count.
- Count = 7: error, then go to DROP.
REQ-012 PRE SHALL handle a non-0x55 byte as the SMD, decoded as follows:
- 0xD5 with count 7: SMD-E, go to EXP.
- 0xE6/0x4C/0x7F/0xB3 with count 7: SMD-S for frame 0/1/2/3, go to PMT.
- 0x61/0x52/0x9E/0x2A with count 6: SMD-C for frame 0/1/2/3, go to FRAG.
- Any other value or count combination: error, go to DROP.
REQ-013 On SMD-S, the block SHALL set active = 1, active frame = n, and expected fragment count = 0.
REQ-014 FRAG SHALL decode the accepted byte 0xE6/0x4C/0x7F/0xB3 as fragment count 0/1/2/3, as follows:
- Valid only if active = 1, the SMD-C frame equals the active frame, and the count equals the expected count.
- If valid: expected count = (expected + 1) mod 4, go to PMT.
- Otherwise: error, go to DROP.
REQ-015 An accepted beat with last in PRE or FRAG SHALL be an error, with return to IDLE.
REQ-016 Preamble, SMD and fragment-count bytes SHALL NOT appear on any output.
REQ-017 EXP and PMT SHALL load each accepted payload beat into the emac/pmac output register respectively, and SHALL assert that register's valid in the next cycle.
REQ-018 Output valid SHALL clear when the consumer takes the beat (valid & ready) and no new beat loads in the same cycle.
REQ-019 Accepted last in EXP/PMT SHALL load the output with last = 1 and return to IDLE.
REQ-020 Output user fields SHALL be as follows; the fields are constant for the whole frame:
- [15:14] type: 00 = E, 01 = S, 10 = C.
- [13:12] frame number; 0 for E.
- [11:10] fragment count; 0 unless C.
- [9:0] zero.
REQ-021 Output keep SHALL be all-ones whenever valid is high.
REQ-022 Output data, user, keep and last SHALL hold stable while valid = 1 and ready = 0.
REQ-023 DROP SHALL accept and discard beats until last, then go to IDLE; drops SHALL emit nothing.
REQ-024 Each error SHALL pulse o_smd_err for exactly one cycle and increment o_err_cnt, which saturates at 0xFFFF.
REQ-025 Latency from payload acceptance to output valid SHALL be exactly 1 cycle, with no bubbles while the consumer holds ready high.
REQ-026 A new frame's header SHALL be accepted while the previous frame's last beat is still pending on an output register.

Reset
REQ-027 While i_rst_n = 0, the block SHALL be in IDLE with active = 0, frame = 0 and expected count = 0.
REQ-028 While i_rst_n = 0, every output SHALL be 0 except o_rx_axis_ready = 1, and o_err_cnt SHALL be 0.
REQ-029 Reset asserted mid-frame SHALL abort the frame immediately, with no last emitted.
REQ-030 After reset release, a stream resumed mid-frame SHALL be handled by the IDLE rules: a non-0x55 first byte is an error and drops the rest of the frame.

Verification
REQ-031 The bench SHALL cover express frames:
- Stimulus: 7×0x55, 0xD5, 64 payload bytes, ready = 1.
- Response: 64 emac beats, user 0x0000, last on beat 64, first beat 1 cycle after acceptance, no errors.
REQ-032 The bench SHALL cover preemptable start plus continuation:
- Stimulus: 7×0x55, 0x4C, payload; then 6×0x55, 0x52, 0xE6, payload.
- Response: pmac user 0x5000, then 0x9000; no errors.
REQ-033 The bench SHALL cover fragment-count mismatch:
- Stimulus: after SMD-S0, send 6×0x55, 0x61, 0x4C.
- Response: o_smd_err pulses, o_err_cnt = 1, the frame is dropped to last, nothing is output.
REQ-034 The bench SHALL cover backpressure:
- Stimulus: express frame with i_emac_axis_ready toggling 1/0.
- Response: o_rx_ready follows REQ-009, no beat lost or duplicated, data stable while stalled.
REQ-035 The bench SHALL cover a bad SMD and reset:
- Stimulus: 7×0x55, 0x00, then reset asserted mid-payload of the next express frame.
- Response: one error, then all outputs return to reset values and o_err_cnt = 0.

Source files
------------

// File: rtl/qbu_rx_smd_dispatch.sv
// Receive-side SMD decoder for frame preemption: strips preamble/SMD/frag-count
// and steers payload to the express or preemptable output register.

module qbu_rx_smd_outreg #(
  parameter int W = 25
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic         ready,
  input  logic [W-1:0] din,
  output logic [W-1:0] dout,
  output logic         valid
);
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dout  <= '0;
      valid <= 1'b0;
    end else if (load) begin
      dout  <= din;
      valid <= 1'b1;
    end else if (valid && ready) begin
      valid <= 1'b0;
    end
  end
endmodule

module qbu_rx_smd_dispatch #(
  parameter int DWIDTH = 8
) (
  input  logic                i_clk,
  input  logic                i_rst_n,
  input  logic [DWIDTH-1:0]   i_rx_axis_data,
  input  logic                i_rx_axis_valid,
  input  logic                i_rx_axis_last,
  output logic                o_rx_axis_ready,
  output logic [DWIDTH-1:0]   o_emac_axis_data,
  output logic [15:0]         o_emac_axis_user,
  output logic [DWIDTH/8-1:0] o_emac_axis_keep,
  output logic                o_emac_axis_last,
  output logic                o_emac_axis_valid,
  input  logic                i_emac_axis_ready,
  output logic [DWIDTH-1:0]   o_pmac_axis_data,
  output logic [15:0]         o_pmac_axis_user,
  output logic [DWIDTH/8-1:0] o_pmac_axis_keep,
  output logic                o_pmac_axis_last,
  output logic                o_pmac_axis_valid,
  input  logic                i_pmac_axis_ready,
  output logic                o_smd_err,
  output logic [15:0]         o_err_cnt
);
  localparam int KW  = DWIDTH / 8;
  localparam int NCH = 2;

  typedef enum logic [2:0] {IDLE, PRE, FRAG, EXP, PMT, DROP} state_t;

  typedef struct packed {
    logic [DWIDTH-1:0] data;
    logic [15:0]       user;
    logic              last;
  } beat_t;

  state_t     state;
  logic [2:0] pre_cnt;
  logic       active;
  logic [1:0] act_frame, exp_frag, c_frame;
  logic [15:0] hdr;

  logic       acc, is55, err_now;
  logic       s_hit, c_hit, e_ok, s_ok, c_ok, f_ok;
  logic [1:0] s_idx, c_idx;

  beat_t                 in_beat;
  beat_t [NCH-1:0]       och;
  logic  [NCH-1:0]       ld, och_rdy, och_vld;

  // 0xE6/4C/7F/B3 serve as both SMD-S frame codes and fragment-count codes
  always_comb begin
    s_hit = 1'b1;
    s_idx = 2'd0;
    case (i_rx_axis_data)
      8'hE6:   s_idx = 2'd0;
      8'h4C:   s_idx = 2'd1;
      8'h7F:   s_idx = 2'd2;
      8'hB3:   s_idx = 2'd3;
      default: s_hit = 1'b0;
    endcase
    c_hit = 1'b1;
    c_idx = 2'd0;
    case (i_rx_axis_data)
      8'h61:   c_idx = 2'd0;
      8'h52:   c_idx = 2'd1;
      8'h9E:   c_idx = 2'd2;
      8'h2A:   c_idx = 2'd3;
      default: c_hit = 1'b0;
    endcase
  end

  assign is55 = (i_rx_axis_data == 8'h55);
  assign e_ok = (pre_cnt == 3'd7) && (i_rx_axis_data == 8'hD5);
  assign s_ok = (pre_cnt == 3'd7) && s_hit;
  assign c_ok = (pre_cnt == 3'd6) && c_hit;
  assign f_ok = s_hit && active && (c_frame == act_frame) && (s_idx == exp_frag);

  always_comb begin
    case (state)
      EXP:     o_rx_axis_ready = ~och_vld[0] | i_emac_axis_ready;
      PMT:     o_rx_axis_ready = ~och_vld[1] | i_pmac_axis_ready;
      default: o_rx_axis_ready = 1'b1;
    endcase
  end

  assign acc = i_rx_axis_valid & o_rx_axis_ready;

  always_comb begin
    err_now = 1'b0;
    if (acc) begin
      case (state)
        IDLE:    err_now = !is55;
        PRE:     err_now = i_rx_axis_last || (is55 ? (pre_cnt == 3'd7) : !(e_ok || s_ok || c_ok));
        FRAG:    err_now = i_rx_axis_last || !f_ok;
        default: err_now = 1'b0;
      endcase
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state     <= IDLE;
      pre_cnt   <= 3'd0;
      active    <= 1'b0;
      act_frame <= 2'd0;
      exp_frag  <= 2'd0;
      c_frame   <= 2'd0;
      hdr       <= 16'h0000;
      o_smd_err <= 1'b0;
      o_err_cnt <= 16'h0000;
    end else begin
      o_smd_err <= err_now;
      if (err_now && o_err_cnt != 16'hFFFF) o_err_cnt <= o_err_cnt + 16'd1;
      if (acc) begin
        case (state)
          IDLE: begin
            if (is55) begin
              state   <= PRE;
              pre_cnt <= 3'd1;
            end else if (!i_rx_axis_last) begin
              state <= DROP;
            end
          end
          PRE: begin
            if (i_rx_axis_last) state <= IDLE;
            else if (is55) begin
              if (pre_cnt == 3'd7) state <= DROP;
              else pre_cnt <= pre_cnt + 3'd1;
            end else if (e_ok) begin
              state <= EXP;
              hdr   <= 16'h0000;
            end else if (s_ok) begin
              state     <= PMT;
              active    <= 1'b1;
              act_frame <= s_idx;
              exp_frag  <= 2'd0;
              hdr       <= {2'b01, s_idx, 12'h000};
            end else if (c_ok) begin
              state   <= FRAG;
              c_frame <= c_idx;
            end else begin
              state <= DROP;
            end
          end
          FRAG: begin
            if (i_rx_axis_last) state <= IDLE;
            else if (f_ok) begin
              state    <= PMT;
              exp_frag <= exp_frag + 2'd1;
              hdr      <= {2'b10, c_frame, s_idx, 10'h000};
            end else begin
              state <= DROP;
            end
          end
          EXP, PMT, DROP: if (i_rx_axis_last) state <= IDLE;
          default: state <= IDLE;
        endcase
      end
    end
  end

  assign in_beat = '{data: i_rx_axis_data, user: hdr, last: i_rx_axis_last};
  assign ld[0]   = acc && (state == EXP);
  assign ld[1]   = acc && (state == PMT);
  assign och_rdy = {i_pmac_axis_ready, i_emac_axis_ready};

  for (genvar c = 0; c < NCH; c++) begin : g_ch
    qbu_rx_smd_outreg #(.W($bits(beat_t))) u_reg (
      .clk   (i_clk),
      .rst_n (i_rst_n),
      .load  (ld[c]),
      .ready (och_rdy[c]),
      .din   (in_beat),
      .dout  (och[c]),
      .valid (och_vld[c])
    );
  end

  assign o_emac_axis_data  = och[0].data;
  assign o_emac_axis_user  = och[0].user;
  assign o_emac_axis_last  = och[0].last;
  assign o_emac_axis_valid = och_vld[0];
  assign o_emac_axis_keep  = {KW{och_vld[0]}};
  assign o_pmac_axis_data  = och[1].data;
  assign o_pmac_axis_user  = och[1].user;
  assign o_pmac_axis_last  = och[1].last;
  assign o_pmac_axis_valid = och_vld[1];
  assign o_pmac_axis_keep  = {KW{och_vld[1]}};

endmodule

// File: tb/tb_qbu_rx_smd_dispatch.sv
// Randomized bench for qbu_rx_smd_dispatch against a frame-level reference model.

module tb_qbu_rx_smd_dispatch;
  localparam int DW = 8;

  logic          i_clk, i_rst_n;
  logic [DW-1:0] i_rx_axis_data;
  logic          i_rx_axis_valid, i_rx_axis_last, o_rx_axis_ready;
  logic [DW-1:0] o_emac_axis_data, o_pmac_axis_data;
  logic [15:0]   o_emac_axis_user, o_pmac_axis_user;
  logic [0:0]    o_emac_axis_keep, o_pmac_axis_keep;
  logic          o_emac_axis_last, o_emac_axis_valid, i_emac_axis_ready;
  logic          o_pmac_axis_last, o_pmac_axis_valid, i_pmac_axis_ready;
  logic          o_smd_err;
  logic [15:0]   o_err_cnt;

  qbu_rx_smd_dispatch #(.DWIDTH(DW)) dut (
    .i_clk(i_clk), .i_rst_n(i_rst_n),
    .i_rx_axis_data(i_rx_axis_data), .i_rx_axis_valid(i_rx_axis_valid),
    .i_rx_axis_last(i_rx_axis_last), .o_rx_axis_ready(o_rx_axis_ready),
    .o_emac_axis_data(o_emac_axis_data), .o_emac_axis_user(o_emac_axis_user),
    .o_emac_axis_keep(o_emac_axis_keep), .o_emac_axis_last(o_emac_axis_last),
    .o_emac_axis_valid(o_emac_axis_valid), .i_emac_axis_ready(i_emac_axis_ready),
    .o_pmac_axis_data(o_pmac_axis_data), .o_pmac_axis_user(o_pmac_axis_user),
    .o_pmac_axis_keep(o_pmac_axis_keep), .o_pmac_axis_last(o_pmac_axis_last),
    .o_pmac_axis_valid(o_pmac_axis_valid), .i_pmac_axis_ready(i_pmac_axis_ready),
    .o_smd_err(o_smd_err), .o_err_cnt(o_err_cnt)
  );

  int checks = 0, errors = 0;
  int cyc = 0, pulse_cnt = 0, exp_err = 0;
  int rdy_mode = 0;
  bit gap_en = 0;
  bit act = 0;
  logic [1:0] afr = 0, efrag = 0;
  logic [24:0] eq[$], pq[$];
  int acc_cyc_q[$], e_cyc_q[$];
  bit [1:0] hold_pend = 0;
  logic [25:0] snap [2];
  logic [7:0] scode [4] = '{8'hE6, 8'h4C, 8'h7F, 8'hB3};
  logic [7:0] ccode [4] = '{8'h61, 8'h52, 8'h9E, 8'h2A};

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic int s_idx(input logic [7:0] b);
    for (int i = 0; i < 4; i++) if (scode[i] == b) return i;
    return -1;
  endfunction

  function automatic int c_idx(input logic [7:0] b);
    for (int i = 0; i < 4; i++) if (ccode[i] == b) return i;
    return -1;
  endfunction

  // Whole-frame reference: classify the header, then queue expected payload beats
  function automatic void model_frame(input logic [7:0] f[$]);
    int n = 0, len = f.size(), st, si, ci, fc;
    bit to_p;
    logic [15:0] u;
    while (n < len && f[n] == 8'h55) n++;
    if (n == 0 || n >= 8 || n >= len - 1) begin exp_err++; return; end
    si = s_idx(f[n]);
    ci = c_idx(f[n]);
    if (f[n] == 8'hD5 && n == 7) begin
      to_p = 0; u = 16'h0000; st = n + 1;
    end else if (si >= 0 && n == 7) begin
      act = 1; afr = 2'(si); efrag = 0;
      to_p = 1; u = 16'h4000 | 16'(si << 12); st = n + 1;
    end else if (ci >= 0 && n == 6) begin
      if (n + 1 >= len - 1) begin exp_err++; return; end
      fc = s_idx(f[n+1]);
      if (fc < 0 || !act || 2'(ci) != afr || 2'(fc) != efrag) begin exp_err++; return; end
      efrag = efrag + 2'd1;
      to_p = 1; u = 16'h8000 | 16'(ci << 12) | 16'(fc << 10); st = n + 2;
    end else begin
      exp_err++; return;
    end
    for (int i = st; i < len; i++) begin
      if (to_p) pq.push_back({i == len - 1, u, f[i]});
      else      eq.push_back({i == len - 1, u, f[i]});
    end
  endfunction

  initial begin
    i_clk = 0;
    forever #5 i_clk = ~i_clk;
  end

  initial forever begin
    @(posedge i_clk);
    cyc++;
  end

  initial forever begin
    @(posedge i_clk);
    #1;
    case (rdy_mode)
      0: begin i_emac_axis_ready = 1; i_pmac_axis_ready = 1; end
      1: begin i_emac_axis_ready = ~i_emac_axis_ready; i_pmac_axis_ready = 1; end
      default: begin
        i_emac_axis_ready = ($urandom_range(0, 3) != 0);
        i_pmac_axis_ready = ($urandom_range(0, 2) != 0);
      end
    endcase
  end

  task automatic mon_ch(input int c, input logic v, input logic r, input logic [24:0] b, input logic k);
    logic [24:0] e;
    if (v) chk(c ? "p_keep" : "e_keep", k, 1);
    if (hold_pend[c]) chk(c ? "p_hold" : "e_hold", {v, b}, snap[c]);
    hold_pend[c] = v && !r;
    snap[c] = {v, b};
    if (v && r) begin
      if (c == 0) begin
        if (eq.size() == 0) chk("e_unexp", 1, 0);
        else begin e = eq.pop_front(); chk("e_beat", b, e); end
        e_cyc_q.push_back(cyc);
      end else begin
        if (pq.size() == 0) chk("p_unexp", 1, 0);
        else begin e = pq.pop_front(); chk("p_beat", b, e); end
      end
    end
  endtask

  initial forever begin
    @(negedge i_clk);
    if (!i_rst_n) begin hold_pend = 0; continue; end
    mon_ch(0, o_emac_axis_valid, i_emac_axis_ready,
           {o_emac_axis_last, o_emac_axis_user, o_emac_axis_data}, o_emac_axis_keep[0]);
    mon_ch(1, o_pmac_axis_valid, i_pmac_axis_ready,
           {o_pmac_axis_last, o_pmac_axis_user, o_pmac_axis_data}, o_pmac_axis_keep[0]);
    if (!o_rx_axis_ready)
      chk("rx_rdy", (o_emac_axis_valid & ~i_emac_axis_ready) | (o_pmac_axis_valid & ~i_pmac_axis_ready), 1);
    if (o_smd_err) pulse_cnt++;
  end

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  task automatic send_beat(input logic [7:0] d, input bit l);
    int t = 0;
    i_rx_axis_data = d; i_rx_axis_last = l; i_rx_axis_valid = 1;
    while (1) begin
      @(negedge i_clk);
      if (o_rx_axis_ready) break;
      t++;
      if (t > 2000) begin
        $display("FAIL rx_stall: ready %0d required 1", o_rx_axis_ready);
        $fatal(1, "stall");
      end
    end
    acc_cyc_q.push_back(cyc);
    @(posedge i_clk);
    #1;
    i_rx_axis_valid = 0;
  endtask

  task automatic send_frame(input logic [7:0] f[$]);
    model_frame(f);
    foreach (f[i]) begin
      if (gap_en && $urandom_range(0, 3) == 0)
        repeat ($urandom_range(1, 3)) begin @(posedge i_clk); #1; end
      send_beat(f[i], i == f.size() - 1);
    end
  endtask

  task automatic drain(input string tag);
    int t = 0;
    while (t < 3000 && (eq.size() != 0 || pq.size() != 0 || o_emac_axis_valid || o_pmac_axis_valid)) begin
      @(negedge i_clk); t++;
    end
    repeat (2) @(negedge i_clk);
    chk({tag, "_q"}, eq.size() + pq.size(), 0);
    chk({tag, "_cnt"}, o_err_cnt, exp_err);
    chk({tag, "_pls"}, pulse_cnt, exp_err);
    @(posedge i_clk);
    #1;
  endtask

  task automatic check_rst();
    chk("rst_rdy", o_rx_axis_ready, 1);
    chk("rst_err", {o_smd_err, o_err_cnt}, 0);
    chk("rst_e", {o_emac_axis_data, o_emac_axis_user, o_emac_axis_keep, o_emac_axis_last, o_emac_axis_valid}, 0);
    chk("rst_p", {o_pmac_axis_data, o_pmac_axis_user, o_pmac_axis_keep, o_pmac_axis_last, o_pmac_axis_valid}, 0);
  endtask

  task automatic mk_frame(input int kind, output logic [7:0] f[$]);
    int plen = $urandom_range(1, 16);
    int np;
    logic [7:0] b;
    f = {};
    np = (kind == 2 || kind == 3 || kind == 9) ? 6 : (kind == 5) ? 8 :
         (kind == 6) ? $urandom_range(1, 5) : (kind == 7) ? 0 : 7;
    for (int i = 0; i < np; i++) f.push_back(8'h55);
    case (kind)
      0, 5, 6: f.push_back(8'hD5);
      1: f.push_back(scode[$urandom_range(0, 3)]);
      2: begin f.push_back(ccode[afr]); f.push_back(scode[efrag]); end
      3: begin f.push_back(ccode[afr]); f.push_back(scode[efrag + 2'($urandom_range(1, 3))]); end
      4: begin
        do b = 8'($urandom); while (b == 8'h55 || b == 8'hD5 || s_idx(b) >= 0);
        f.push_back(b);
      end
      7: begin
        do b = 8'($urandom); while (b == 8'h55);
        f.push_back(b);
      end
      9: begin f.push_back(ccode[afr + 2'd1]); f.push_back(scode[efrag]); end
      default: plen = 0;
    endcase
    for (int i = 0; i < plen; i++) f.push_back(8'($urandom));
  endtask

  initial begin
    logic [7:0] fr[$];
    int k;
    logic [7:0] b;
    i_rst_n = 0; i_rx_axis_data = 0; i_rx_axis_valid = 0; i_rx_axis_last = 0;
    i_emac_axis_ready = 1; i_pmac_axis_ready = 1;
    repeat (3) @(posedge i_clk);
    #1;
    check_rst();
    i_rst_n = 1;
    @(posedge i_clk); #1;

    // express frame, full-rate consumer: one-cycle latency, no bubbles
    fr = {};
    for (int i = 0; i < 7; i++) fr.push_back(8'h55);
    fr.push_back(8'hD5);
    for (int i = 0; i < 64; i++) fr.push_back(8'($urandom));
    acc_cyc_q.delete(); e_cyc_q.delete();
    send_frame(fr);
    drain("exp64");
    chk("lat_n", e_cyc_q.size(), 64);
    for (int i = 0; i < 64; i++)
      if (i < e_cyc_q.size()) chk("lat", e_cyc_q[i], acc_cyc_q[8 + i] + 1);

    // SMD-S1 then SMD-C1 fragment 0
    fr = {};
    for (int i = 0; i < 7; i++) fr.push_back(8'h55);
    fr.push_back(8'h4C);
    for (int i = 0; i < 10; i++) fr.push_back(8'($urandom));
    send_frame(fr);
    fr = {};
    for (int i = 0; i < 6; i++) fr.push_back(8'h55);
    fr.push_back(8'h52); fr.push_back(8'hE6);
    for (int i = 0; i < 10; i++) fr.push_back(8'($urandom));
    send_frame(fr);
    drain("s_c");

    // fragment-count mismatch after SMD-S0
    fr = {};
    for (int i = 0; i < 7; i++) fr.push_back(8'h55);
    fr.push_back(8'hE6);
    for (int i = 0; i < 5; i++) fr.push_back(8'($urandom));
    send_frame(fr);
    fr = {};
    for (int i = 0; i < 6; i++) fr.push_back(8'h55);
    fr.push_back(8'h61); fr.push_back(8'h4C);
    for (int i = 0; i < 8; i++) fr.push_back(8'($urandom));
    send_frame(fr);
    drain("fmis");
    chk("fmis_cnt1", o_err_cnt, 1);

    // backpressure on express
    rdy_mode = 1;
    mk_frame(0, fr);
    for (int i = 0; i < 24; i++) fr.push_back(8'($urandom));
    send_frame(fr);
    drain("bp");

    // randomized mix
    rdy_mode = 2; gap_en = 1;
    for (int n = 0; n < 150; n++) begin
      k = $urandom_range(0, 13);
      if (k > 9) k = (k - 10) % 3;
      mk_frame(k, fr);
      send_frame(fr);
      if (n % 10 == 9) drain("rnd");
    end
    drain("rnd_end");

    // bad SMD, then reset in the middle of an express payload
    rdy_mode = 0; gap_en = 0;
    fr = {};
    for (int i = 0; i < 7; i++) fr.push_back(8'h55);
    fr.push_back(8'h00); fr.push_back(8'h11); fr.push_back(8'h22);
    send_frame(fr);
    drain("badsmd");
    for (int i = 0; i < 7; i++) send_beat(8'h55, 0);
    send_beat(8'hD5, 0);
    for (int i = 0; i < 10; i++) begin
      b = 8'($urandom);
      eq.push_back({1'b0, 16'h0000, b});
      send_beat(b, 0);
    end
    repeat (3) begin @(posedge i_clk); #1; end
    chk("pre_rst_q", eq.size(), 0);
    chk("pre_rst_cnt", o_err_cnt, exp_err);
    i_rst_n = 0;
    #1;
    check_rst();
    act = 0; afr = 0; efrag = 0; exp_err = 0; pulse_cnt = 0;
    eq.delete(); pq.delete();
    repeat (2) begin @(posedge i_clk); #1; end
    check_rst();
    i_rst_n = 1;
    @(posedge i_clk); #1;
    fr = {8'hA0};
    for (int i = 0; i < 11; i++) fr.push_back(8'($urandom));
    send_frame(fr);
    drain("resume");
    mk_frame(0, fr);
    send_frame(fr);
    drain("post");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
